// File: rtl/hwpe_ctrl_regfile_bus_if.sv
// Bus target front-end for the latch-based control register file.
// Accepts req/gnt requests, drives the register file read/write strobes,
// returns one response per accepted request one cycle later and holds it
// until r_ready. Also sequences a one-cycle soft clear from IDLE.
module hwpe_ctrl_regfile_bus_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    bus_req,
   output logic                    bus_gnt,
   input  logic [31:0]             bus_add,
   input  logic                    bus_wen,
   input  logic [DATA_WIDTH/8-1:0] bus_be,
   input  logic [DATA_WIDTH-1:0]   bus_data,
   input  logic [ID_WIDTH-1:0]     bus_id,
   output logic                    bus_r_valid,
   input  logic                    bus_r_ready,
   output logic [DATA_WIDTH-1:0]   bus_r_data,
   output logic [ID_WIDTH-1:0]     bus_r_id,
   output logic                    bus_r_err,
   input  logic                    wr_lock,
   input  logic                    clear_req,
   output logic                    clear_ack,
   output logic                    rf_clear,
   output logic                    rf_ren,
   output logic [ADDR_WIDTH-1:0]   rf_raddr,
   input  logic [DATA_WIDTH-1:0]   rf_rdata,
   output logic                    rf_wen,
   output logic [ADDR_WIDTH-1:0]   rf_waddr,
   output logic [DATA_WIDTH-1:0]   rf_wdata,
   output logic [DATA_WIDTH/8-1:0] rf_wbe
);

   typedef enum logic [1:0] {IDLE, RESP, CLEAR} state_t;

   state_t                state_reg;
   logic                  r_valid_reg;
   logic                  r_err_reg;
   logic [ID_WIDTH-1:0]   r_id_reg;
   logic                  rd_pass_reg;   // response carries register-file read data
   logic                  clear_reg;

   logic                  in_range;
   logic                  unused_add_lsb;

   // Byte-offset bits of the address carry no information for word registers.
   assign unused_add_lsb = ^bus_add[1:0];

   assign in_range = (bus_add[31:ADDR_WIDTH+2] == '0);

   // Accept in IDLE, or in RESP when the held response is consumed this same cycle.
   assign bus_gnt = bus_req & ~clear_req &
                    ((state_reg == IDLE) | ((state_reg == RESP) & bus_r_ready));

   // Register-file strobes are issued combinationally in the accept cycle.
   assign rf_ren   = bus_gnt & bus_wen & in_range;
   assign rf_raddr = bus_add[ADDR_WIDTH+1:2];
   assign rf_wen   = bus_gnt & ~bus_wen & in_range & ~wr_lock;
   assign rf_waddr = bus_add[ADDR_WIDTH+1:2];
   assign rf_wdata = bus_data;
   assign rf_wbe   = bus_be;

   // Read data passes straight through: the register file's read address
   // only moves on rf_ren, which cannot fire while a response is held.
   assign bus_r_data  = (r_valid_reg & rd_pass_reg) ? rf_rdata : '0;
   assign bus_r_valid = r_valid_reg;
   assign bus_r_id    = r_id_reg;
   assign bus_r_err   = r_err_reg;
   assign rf_clear    = clear_reg;
   assign clear_ack   = clear_reg;

   // Control FSM with registered response and clear outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         r_valid_reg <= 1'b0;
         r_err_reg   <= 1'b0;
         r_id_reg    <= '0;
         rd_pass_reg <= 1'b0;
         clear_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clear_req) begin
                  state_reg <= CLEAR;
                  clear_reg <= 1'b1;
               end else if (bus_gnt) begin
                  state_reg   <= RESP;
                  r_valid_reg <= 1'b1;
                  r_id_reg    <= bus_id;
                  r_err_reg   <= ~in_range | (~bus_wen & wr_lock);
                  rd_pass_reg <= bus_wen & in_range;
               end
            end
            RESP: begin
               if (bus_r_ready) begin
                  if (bus_gnt) begin
                     r_valid_reg <= 1'b1;
                     r_id_reg    <= bus_id;
                     r_err_reg   <= ~in_range | (~bus_wen & wr_lock);
                     rd_pass_reg <= bus_wen & in_range;
                  end else begin
                     state_reg   <= IDLE;
                     r_valid_reg <= 1'b0;
                     r_id_reg    <= '0;
                     r_err_reg   <= 1'b0;
                     rd_pass_reg <= 1'b0;
                  end
               end
            end
            CLEAR: begin
               state_reg <= IDLE;
               clear_reg <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               clear_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bus_if.sv
// Directed testbench for hwpe_ctrl_regfile_bus_if with a small behavioural
// register file (one-cycle read latency, byte-enabled writes, clear).
module tb_hwpe_ctrl_regfile_bus_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] bus_add;
   logic        bus_wen;
   logic [3:0]  bus_be;
   logic [31:0] bus_data;
   logic [3:0]  bus_id;
   logic        bus_r_valid;
   logic        bus_r_ready;
   logic [31:0] bus_r_data;
   logic [3:0]  bus_r_id;
   logic        bus_r_err;
   logic        wr_lock;
   logic        clear_req;
   logic        clear_ack;
   logic        rf_clear;
   logic        rf_ren;
   logic [4:0]  rf_raddr;
   logic [31:0] rf_rdata;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [3:0]  rf_wbe;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   hwpe_ctrl_regfile_bus_if #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32), .ID_WIDTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_add(bus_add), .bus_wen(bus_wen),
      .bus_be(bus_be), .bus_data(bus_data), .bus_id(bus_id),
      .bus_r_valid(bus_r_valid), .bus_r_ready(bus_r_ready), .bus_r_data(bus_r_data),
      .bus_r_id(bus_r_id), .bus_r_err(bus_r_err),
      .wr_lock(wr_lock), .clear_req(clear_req), .clear_ack(clear_ack),
      .rf_clear(rf_clear), .rf_ren(rf_ren), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wbe(rf_wbe)
   );

   // Register file model: writes land at the edge ending the write cycle,
   // read address captured on rf_ren, data visible the following cycle.
   logic [31:0] mem [32];
   logic [4:0]  raddr_q;
   assign rf_rdata = mem[raddr_q];

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 32; k++) mem[k] <= '0;
         raddr_q <= '0;
      end else begin
         if (rf_clear) begin
            for (int k = 0; k < 32; k++) mem[k] <= '0;
         end else if (rf_wen) begin
            for (int b = 0; b < 4; b++)
               if (rf_wbe[b]) mem[rf_waddr][8*b +: 8] <= rf_wdata[8*b +: 8];
         end
         if (rf_ren) raddr_q <= rf_raddr;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [3:0] id);
      bus_req  = 1'b1;
      bus_wen  = wen;
      bus_add  = addr;
      bus_data = data;
      bus_be   = be;
      bus_id   = id;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bus_req = 1'b0; bus_add = '0; bus_wen = 1'b0; bus_be = '0;
      bus_data = '0; bus_id = '0; bus_r_ready = 1'b1; wr_lock = 1'b0; clear_req = 1'b0;
      repeat (3) tick();
      // reset state
      check("rst_gnt", bus_gnt, 0);
      check("rst_r_valid", bus_r_valid, 0);
      check("rst_r_data", bus_r_data, 0);
      check("rst_r_id", bus_r_id, 0);
      check("rst_r_err", bus_r_err, 0);
      check("rst_clear_ack", clear_ack, 0);
      check("rst_rf_clear", rf_clear, 0);
      check("rst_rf_ren", rf_ren, 0);
      check("rst_rf_wen", rf_wen, 0);
      rst = 1'b0;
      tick();

      // write 0xDEADBEEF to 0x08, id 3
      set_req(1'b0, 32'h08, 32'hDEADBEEF, 4'hF, 4'd3);
      #1;
      check("wr1_gnt", bus_gnt, 1);
      check("wr1_rf_wen", rf_wen, 1);
      check("wr1_rf_waddr", rf_waddr, 2);
      check("wr1_rf_wdata", rf_wdata, 32'hDEADBEEF);
      check("wr1_rf_wbe", rf_wbe, 4'hF);
      check("wr1_no_resp_yet", bus_r_valid, 0);
      tick();
      // read 0x08, id 5, back-to-back
      set_req(1'b1, 32'h08, 32'h0, 4'h0, 4'd5);
      #1;
      check("wr1_r_valid", bus_r_valid, 1);
      check("wr1_r_id", bus_r_id, 3);
      check("wr1_r_data", bus_r_data, 0);
      check("wr1_r_err", bus_r_err, 0);
      check("rd1_gnt", bus_gnt, 1);
      check("rd1_rf_ren", rf_ren, 1);
      check("rd1_rf_raddr", rf_raddr, 2);
      tick();
      // byte write be=0x2
      set_req(1'b0, 32'h08, 32'h0000AB00, 4'h2, 4'd6);
      #1;
      check("rd1_r_valid", bus_r_valid, 1);
      check("rd1_r_id", bus_r_id, 5);
      check("rd1_r_data", bus_r_data, 32'hDEADBEEF);
      tick();
      set_req(1'b1, 32'h08, 32'h0, 4'h0, 4'd7);
      #1;
      check("wr2_r_id", bus_r_id, 6);
      check("wr2_r_data", bus_r_data, 0);
      tick();

      // backpressure: new request pending while r_ready=0 for 4 cycles
      bus_r_ready = 1'b0;
      set_req(1'b1, 32'h0C, 32'h0, 4'h0, 4'd9);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("bp_r_valid", bus_r_valid, 1);
         check("bp_r_data", bus_r_data, 32'hDEADABEF);
         check("bp_r_id", bus_r_id, 7);
         check("bp_gnt", bus_gnt, 0);
         check("bp_rf_ren", rf_ren, 0);
         tick();
      end
      bus_r_ready = 1'b1;
      #1;
      check("bp_release_gnt", bus_gnt, 1);
      tick();
      bus_req = 1'b0;
      #1;
      check("bp_next_id", bus_r_id, 9);
      check("bp_next_data", bus_r_data, 0);
      tick();
      check("idle_r_valid", bus_r_valid, 0);

      // locked write is dropped
      set_req(1'b0, 32'h0C, 32'h55AA55AA, 4'hF, 4'd1);
      tick();
      wr_lock = 1'b1;
      set_req(1'b0, 32'h0C, 32'h00001234, 4'hF, 4'd1);
      #1;
      check("lock_gnt", bus_gnt, 1);
      check("lock_rf_wen", rf_wen, 0);
      tick();
      wr_lock = 1'b0;
      set_req(1'b1, 32'h0C, 32'h0, 4'h0, 4'd2);
      #1;
      check("lock_r_err", bus_r_err, 1);
      check("lock_r_data", bus_r_data, 0);
      tick();
      // out-of-range read
      set_req(1'b1, 32'h400, 32'h0, 4'h0, 4'd4);
      #1;
      check("lock_readback", bus_r_data, 32'h55AA55AA);
      check("lock_readback_err", bus_r_err, 0);
      check("oor_gnt", bus_gnt, 1);
      check("oor_rf_ren", rf_ren, 0);
      tick();
      bus_req = 1'b0;
      #1;
      check("oor_r_err", bus_r_err, 1);
      check("oor_r_data", bus_r_data, 0);
      check("oor_r_id", bus_r_id, 4);
      tick();

      // clear has priority over a simultaneous request
      clear_req = 1'b1;
      set_req(1'b1, 32'h08, 32'h0, 4'h0, 4'd8);
      #1;
      check("clr_gnt", bus_gnt, 0);
      tick();
      bus_req = 1'b0;
      #1;
      check("clr_rf_clear", rf_clear, 1);
      check("clr_ack", clear_ack, 1);
      check("clr_r_valid", bus_r_valid, 0);
      tick();
      clear_req = 1'b0;
      #1;
      check("clr_rf_clear_off", rf_clear, 0);
      check("clr_ack_off", clear_ack, 0);
      for (int i = 0; i <= 32; i++) begin
         if (i < 32) set_req(1'b1, 32'(i * 4), 32'h0, 4'h0, 4'(i));
         else bus_req = 1'b0;
         #1;
         if (i > 0) begin
            check("clr_rd_valid", bus_r_valid, 1);
            check("clr_rd_data", bus_r_data, 0);
            check("clr_rd_id", bus_r_id, 32'((i - 1) % 16));
         end
         tick();
      end

      // 8 back-to-back writes then 8 back-to-back reads
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) set_req(1'b0, 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 4'(i));
         else bus_req = 1'b0;
         #1;
         if (i > 0) begin
            check("b2b_wr_valid", bus_r_valid, 1);
            check("b2b_wr_id", bus_r_id, 32'(i - 1));
         end
         tick();
      end
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) set_req(1'b1, 32'(i * 4), 32'h0, 4'h0, 4'(i + 8));
         else bus_req = 1'b0;
         #1;
         if (i > 0) begin
            check("b2b_rd_valid", bus_r_valid, 1);
            check("b2b_rd_id", bus_r_id, 32'(i + 7));
            check("b2b_rd_data", bus_r_data, 32'h1000_0000 + 32'(i - 1));
         end
         tick();
      end
      check("b2b_end_idle", bus_r_valid, 0);

      // all-zero byte enables: accepted, no error, contents unchanged
      set_req(1'b0, 32'h00, 32'hFFFFFFFF, 4'h0, 4'hA);
      #1;
      check("be0_gnt", bus_gnt, 1);
      check("be0_rf_wbe", rf_wbe, 0);
      tick();
      set_req(1'b1, 32'h00, 32'h0, 4'h0, 4'hB);
      #1;
      check("be0_r_valid", bus_r_valid, 1);
      check("be0_r_err", bus_r_err, 0);
      check("be0_r_id", bus_r_id, 4'hA);
      tick();
      bus_req = 1'b0;
      #1;
      check("be0_readback", bus_r_data, 32'h1000_0000);
      tick();

      // reset mid-burst drops the pending response
      for (int i = 0; i < 4; i++) begin
         set_req(1'b1, 32'(i * 4), 32'h0, 4'h0, 4'(i));
         if (i == 3) rst = 1'b1;
         #1;
         if (i > 0) check("rstb_r_data", bus_r_data, 32'h1000_0000 + 32'(i - 1));
         tick();
      end
      rst = 1'b0;
      bus_req = 1'b0;
      #1;
      check("rstb_r_valid", bus_r_valid, 0);
      check("rstb_r_id", bus_r_id, 0);
      set_req(1'b1, 32'h04, 32'h0, 4'h0, 4'd5);
      #1;
      check("rstb_idle_gnt", bus_gnt, 1);
      tick();
      bus_req = 1'b0;
      #1;
      check("rstb_resp_valid", bus_r_valid, 1);
      check("rstb_resp_id", bus_r_id, 5);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
